pipe_ctrl_unit: RTL and testbench

- Pipelined successor to the single-cycle main decoder.
- Decodes opcode/funct in ID into a control bundle and carries it through ID/EX, EX/MEM and MEM/WB registers.
- Computes the destination register in ID, detects load-use hazards, and inserts bubbles on stall or flush.
- Sits between the IF/ID register and the datapath; the datapath consumes the per-stage control outputs directly.

---
 rtl/pcu_pkg.sv | 72 +++++++
 rtl/pcu_decode.sv | 117 +++++++++++
 rtl/pipe_ctrl_unit.sv | 137 +++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcu_pkg.sv
// pcu_pkg: shared definitions for the pipelined control unit.
//   - opcode / funct encodings decoded in ID
//   - ALU operation and write-back source encodings
//   - ctrl_t: the control bundle carried through ID/EX, EX/MEM and MEM/WB
//   - CTRL_NOP: the all-zero bubble
//   - is_r_funct(): the set of R-type funct codes this pipeline accepts
package pcu_pkg;

    localparam logic [5:0] OP_RTYPE    = 6'b000000;
    localparam logic [5:0] OP_LW       = 6'b100011;
    localparam logic [5:0] OP_SW       = 6'b101011;
    localparam logic [5:0] OP_ADDI     = 6'b001000;
    localparam logic [5:0] OP_ORI      = 6'b001101;
    localparam logic [5:0] OP_ANDI     = 6'b001100;
    localparam logic [5:0] OP_SLTI     = 6'b001010;
    localparam logic [5:0] OP_LUI      = 6'b001111;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [5:0] OP_BNE      = 6'b000101;
    localparam logic [5:0] OP_J        = 6'b000010;
    localparam logic [5:0] OP_JAL      = 6'b000011;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;

    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_MUL = 6'b000010;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_R   = 3'b010,
        ALU_OR  = 3'b011,
        ALU_AND = 3'b100,
        ALU_SLT = 3'b101,
        ALU_LUI = 3'b110,
        ALU_MUL = 3'b111
    } aluop_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC8 = 2'b10
    } memtoreg_e;

    typedef struct packed {
        logic      alusrc;
        aluop_e    aluop;
        logic      branch;
        logic      bne;
        logic      jump;
        logic      jr;
        logic      mem_read;
        logic      mem_write;
        logic      regwrite;
        memtoreg_e memtoreg;
        logic [4:0] wreg;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // ALU-type R functs handled by the datapath (jr is decoded separately).
    function automatic logic is_r_funct(input logic [5:0] funct);
        case (funct)
            6'b000000, 6'b000010, 6'b000011,              // sll srl sra
            6'b100000, 6'b100001, 6'b100010, 6'b100011,   // add addu sub subu
            6'b100100, 6'b100101, 6'b100110, 6'b100111,   // and or xor nor
            6'b101010, 6'b101011:                         // slt sltu
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pcu_decode.sv
// pcu_decode: purely combinational ID-stage decoder.
// Optional feature macro: PCU_MUL_EN (adds mul, opcode 011100 / funct 000010).
// Ports:
//   valid    in   IF/ID holds a real instruction (0 decodes as a bubble)
//   opcode   in   instruction [31:26]
//   funct    in   instruction [5:0]
//   rt, rd   in   candidate destination register indices
//   ctrl     out  decoded control bundle
//   illegal  out  valid instruction with undefined encoding
//   reads_rt out  instruction uses rt as a source (R-type, sw, beq, bne)
module pcu_decode
    import pcu_pkg::*;
#(
    parameter int RA_REG = 31
) (
    input  logic       valid,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    output ctrl_t      ctrl,
    output logic       illegal,
    output logic       reads_rt
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        ctrl     = CTRL_NOP;
        illegal  = 1'b0;
        reads_rt = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                reads_rt   = 1'b1;
                ctrl.aluop = ALU_R;
                if (funct == FN_JR) begin
                    ctrl.jr = 1'b1;
                end else if (is_r_funct(funct)) begin
                    ctrl.regwrite = 1'b1;
                    ctrl.wreg     = rd;
                end else begin
                    ctrl    = CTRL_NOP;
                    illegal = 1'b1;
                end
            end
            OP_LW: begin
                ctrl.alusrc   = 1'b1;
                ctrl.mem_read = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = WB_MEM;
                ctrl.wreg     = rt;
            end
            OP_SW: begin
                reads_rt       = 1'b1;
                ctrl.alusrc    = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_ADDI, OP_ORI, OP_ANDI, OP_SLTI, OP_LUI: begin
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.wreg     = rt;
                case (opcode)
                    OP_ORI:  ctrl.aluop = ALU_OR;
                    OP_ANDI: ctrl.aluop = ALU_AND;
                    OP_SLTI: ctrl.aluop = ALU_SLT;
                    OP_LUI:  ctrl.aluop = ALU_LUI;
                    default: ctrl.aluop = ALU_ADD;
                endcase
            end
            OP_BEQ: begin
                reads_rt    = 1'b1;
                ctrl.aluop  = ALU_SUB;
                ctrl.branch = 1'b1;
            end
            OP_BNE: begin
                reads_rt   = 1'b1;
                ctrl.aluop = ALU_SUB;
                ctrl.bne   = 1'b1;
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            OP_JAL: begin
                ctrl.jump     = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = WB_PC8;
                ctrl.wreg     = 5'(RA_REG);
            end
`ifdef PCU_MUL_EN
            OP_SPECIAL2: begin
                if (funct == FN_MUL) begin
                    ctrl.aluop    = ALU_MUL;
                    ctrl.regwrite = 1'b1;
                    ctrl.wreg     = rd;
                end else begin
                    illegal = 1'b1;
                end
            end
`endif
            default: begin
                illegal = 1'b1;
            end
        endcase

        // Writes to r0 are discarded at decode so later stages never see them.
        if (ctrl.wreg == 5'd0) begin
            ctrl.regwrite = 1'b0;
        end

        if (!valid) begin
            ctrl     = CTRL_NOP;
            illegal  = 1'b0;
            reads_rt = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipelined main control. Decodes the IF/ID instruction into a
// ctrl_t bundle and carries it through ID/EX, EX/MEM and MEM/WB; detects
// load-use hazards and inserts bubbles on stall or flush.
// Optional feature macro: PCU_MUL_EN (multi-cycle mul holding EX for MUL_LAT cycles).
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   id_valid/opcode/funct  IF/ID instruction fields
//   id_rs/id_rt/id_rd      register indices of the ID instruction
//   ex_flush               kill the ID instruction (branch/jump resolved in EX)
//   stall                  hold PC and IF/ID this cycle
//   illegal                ID holds a valid undefined encoding (combinational)
//   ex_*                   EX-stage controls (ID/EX register)
//   mem_read/mem_write     MEM-stage controls (EX/MEM register)
//   wb_*                   WB-stage controls (MEM/WB register)
module pipe_ctrl_unit
    import pcu_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int MUL_LAT = 4,
    parameter int RA_REG  = 31
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [5:0]         id_opcode,
    input  logic [5:0]         id_funct,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic [4:0]         id_rd,
    input  logic               ex_flush,
    output logic               stall,
    output logic               illegal,
    output logic               ex_alusrc,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               ex_branch,
    output logic               ex_bne,
    output logic               ex_jump,
    output logic               ex_jr,
    output logic               ex_mul_busy,
    output logic               mem_read,
    output logic               mem_write,
    output logic               wb_regwrite,
    output logic [1:0]         wb_memtoreg,
    output logic [4:0]         wb_wreg
);

    ctrl_t id_ctrl;
    logic  id_reads_rt;
    ctrl_t idex_q,  idex_d;
    ctrl_t exmem_q, exmem_d;
    ctrl_t memwb_q, memwb_d;
    logic  load_use;
    logic  mul_busy;

    pcu_decode #(.RA_REG(RA_REG)) u_decode (
        .valid    (id_valid),
        .opcode   (id_opcode),
        .funct    (id_funct),
        .rt       (id_rt),
        .rd       (id_rd),
        .ctrl     (id_ctrl),
        .illegal  (illegal),
        .reads_rt (id_reads_rt)
    );

    // A load in EX whose result is needed by the ID instruction.
    assign load_use = id_valid && idex_q.mem_read && (idex_q.wreg != 5'd0) &&
                      ((idex_q.wreg == id_rs) || (id_reads_rt && (idex_q.wreg == id_rt)));

    // Flush overrides a load-use stall; a busy mul always stalls.
    assign stall = (load_use && !ex_flush) || mul_busy;

`ifdef PCU_MUL_EN
    logic [3:0] mul_cnt_q, mul_cnt_d;

    assign mul_busy = (mul_cnt_q != 4'd0);

    always_comb begin
        mul_cnt_d = mul_cnt_q;
        if (mul_busy) begin
            mul_cnt_d = mul_cnt_q - 4'd1;
        end else if (!ex_flush && !load_use && (id_ctrl.aluop == ALU_MUL)) begin
            // The mul is entering EX now; it stays there MUL_LAT cycles in total.
            mul_cnt_d = 4'(MUL_LAT - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mul_cnt_q <= 4'd0;
        end else begin
            mul_cnt_q <= mul_cnt_d;
        end
    end
`else
    assign mul_busy = 1'b0;
`endif

    always_comb begin
        if (mul_busy) begin
            idex_d = idex_q;
        end else if (ex_flush || load_use) begin
            idex_d = CTRL_NOP;
        end else begin
            idex_d = id_ctrl;
        end
        exmem_d = mul_busy ? CTRL_NOP : idex_q;
        memwb_d = exmem_q;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every stage samples the previous stage's old value.
        if (reset) begin
            idex_q  <= CTRL_NOP;
            exmem_q <= CTRL_NOP;
            memwb_q <= CTRL_NOP;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign ex_alusrc   = idex_q.alusrc;
    assign ex_aluop    = ALUOP_W'(idex_q.aluop);
    assign ex_branch   = idex_q.branch;
    assign ex_bne      = idex_q.bne;
    assign ex_jump     = idex_q.jump;
    assign ex_jr       = idex_q.jr;
    assign ex_mul_busy = mul_busy;
    assign mem_read    = exmem_q.mem_read;
    assign mem_write   = exmem_q.mem_write;
    assign wb_regwrite = memwb_q.regwrite;
    assign wb_memtoreg = memwb_q.memtoreg;
    assign wb_wreg     = memwb_q.wreg;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: directed self-checking bench for pipe_ctrl_unit.
// Runs with or without PCU_MUL_EN; the mul section adapts to the build.
module tb_pipe_ctrl_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [5:0] id_opcode;
    logic [5:0] id_funct;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_rd;
    logic       ex_flush;
    logic       stall;
    logic       illegal;
    logic       ex_alusrc;
    logic [2:0] ex_aluop;
    logic       ex_branch;
    logic       ex_bne;
    logic       ex_jump;
    logic       ex_jr;
    logic       ex_mul_busy;
    logic       mem_read;
    logic       mem_write;
    logic       wb_regwrite;
    logic [1:0] wb_memtoreg;
    logic [4:0] wb_wreg;

    int errors = 0;
    int checks = 0;

    pipe_ctrl_unit #(.ALUOP_W(3), .MUL_LAT(4), .RA_REG(31)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_opcode   (id_opcode),
        .id_funct    (id_funct),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .ex_flush    (ex_flush),
        .stall       (stall),
        .illegal     (illegal),
        .ex_alusrc   (ex_alusrc),
        .ex_aluop    (ex_aluop),
        .ex_branch   (ex_branch),
        .ex_bne      (ex_bne),
        .ex_jump     (ex_jump),
        .ex_jr       (ex_jr),
        .ex_mul_busy (ex_mul_busy),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .wb_regwrite (wb_regwrite),
        .wb_memtoreg (wb_memtoreg),
        .wb_wreg     (wb_wreg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample point: 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        id_valid  = v;
        id_opcode = op;
        id_funct  = fn;
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
    endtask

    task automatic nop();
        set_id(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic drain();
        nop();
        ex_flush = 1'b0;
        repeat (3) tick();
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({stall, ex_alusrc, ex_aluop, ex_branch, ex_bne, ex_jump, ex_jr,
                    ex_mul_busy, mem_read, mem_write, wb_regwrite, wb_memtoreg, wb_wreg});
    endfunction

    function automatic logic [31:0] ex_bundle();
        return 32'({ex_alusrc, ex_aluop, ex_branch, ex_bne, ex_jump, ex_jr});
    endfunction

    initial begin
        reset    = 1'b1;
        ex_flush = 1'b0;
        // Reset held two cycles with a lw waiting in IF/ID.
        set_id(1'b1, 6'b100011, 6'd0, 5'd0, 5'd3, 5'd0);
        tick();
        check("reset_c1_outputs", all_outs(), 32'd0);
        tick();
        check("reset_c2_outputs", all_outs(), 32'd0);
        reset = 1'b0;
        #1;
        check("release_c1_outputs", all_outs(), 32'd0);
        tick();
        check("release_lw_in_ex", ex_bundle(), 32'b1_000_0000);
        drain();

        // addi r1 / ori r2 / lw r3 / sw: no hazards.
        set_id(1'b1, 6'b001000, 6'd0, 5'd0, 5'd1, 5'd0);
        tick();
        check("addi_ex", ex_bundle(), 32'b1_000_0000);
        set_id(1'b1, 6'b001101, 6'd0, 5'd0, 5'd2, 5'd0);
        tick();
        check("ori_ex", ex_bundle(), 32'b1_011_0000);
        set_id(1'b1, 6'b100011, 6'd0, 5'd0, 5'd3, 5'd0);
        tick();
        check("seq_wb1_addi", {wb_regwrite, wb_wreg}, {1'b1, 5'd1});
        set_id(1'b1, 6'b101011, 6'd0, 5'd0, 5'd4, 5'd0);
        #1;
        check("seq_sw_no_stall", stall, 1'b0);
        tick();
        check("seq_lw_mem_read", mem_read, 1'b1);
        check("seq_wb2_ori", {wb_regwrite, wb_wreg}, {1'b1, 5'd2});
        nop();
        tick();
        check("seq_sw_mem_write", mem_write, 1'b1);
        check("seq_wb3_lw", {wb_regwrite, wb_memtoreg, wb_wreg}, {1'b1, 2'b01, 5'd3});
        tick();
        check("seq_wb4_sw", wb_regwrite, 1'b0);
        drain();

        // lw r5 ; add r6,r5,r7 -> one bubble.
        set_id(1'b1, 6'b100011, 6'd0, 5'd0, 5'd5, 5'd0);
        tick();
        set_id(1'b1, 6'b000000, 6'b100000, 5'd5, 5'd7, 5'd6);
        #1;
        check("lu_stall", stall, 1'b1);
        tick();
        check("lu_bubble_ex", ex_bundle(), 32'd0);
        check("lu_lw_mem", mem_read, 1'b1);
        check("lu_stall_released", stall, 1'b0);
        tick();
        check("lu_add_ex", ex_bundle(), 32'b0_010_0000);
        nop();
        tick();
        tick();
        check("lu_add_wb", {wb_regwrite, wb_wreg}, {1'b1, 5'd6});
        drain();

        // rt-side: sw reads rt (stall), addi does not (no stall).
        set_id(1'b1, 6'b100011, 6'd0, 5'd0, 5'd5, 5'd0);
        tick();
        set_id(1'b1, 6'b101011, 6'd0, 5'd0, 5'd5, 5'd0);
        #1;
        check("lu_sw_rt_stall", stall, 1'b1);
        set_id(1'b1, 6'b001000, 6'd0, 5'd0, 5'd5, 5'd0);
        #1;
        check("lu_addi_rt_nostall", stall, 1'b0);
        drain();

        // Load to r0 never causes a hazard.
        set_id(1'b1, 6'b100011, 6'd0, 5'd0, 5'd0, 5'd0);
        tick();
        set_id(1'b1, 6'b000000, 6'b100000, 5'd0, 5'd0, 5'd1);
        #1;
        check("lu_r0_nostall", stall, 1'b0);
        drain();

        // Flush beats load-use; then unflushed jal.
        set_id(1'b1, 6'b100011, 6'd0, 5'd0, 5'd9, 5'd0);
        tick();
        set_id(1'b1, 6'b000011, 6'd0, 5'd9, 5'd0, 5'd0);
        ex_flush = 1'b1;
        #1;
        check("flush_stall", stall, 1'b0);
        tick();
        check("flush_bubble_ex", ex_bundle(), 32'd0);
        ex_flush = 1'b0;
        #1;
        check("jal_no_stall", stall, 1'b0);
        tick();
        check("jal_ex", ex_bundle(), 32'b0_000_0010);
        nop();
        tick();
        tick();
        check("jal_wb", {wb_regwrite, wb_memtoreg, wb_wreg}, {1'b1, 2'b10, 5'd31});
        drain();

        // Undefined opcode.
        set_id(1'b1, 6'b111111, 6'd0, 5'd1, 5'd2, 5'd3);
        #1;
        check("illegal_valid", illegal, 1'b1);
        tick();
        check("illegal_nop_ex", ex_bundle(), 32'd0);
        set_id(1'b0, 6'b111111, 6'd0, 5'd1, 5'd2, 5'd3);
        #1;
        check("illegal_invalid", illegal, 1'b0);
        // Undefined R funct.
        set_id(1'b1, 6'b000000, 6'b111111, 5'd1, 5'd2, 5'd3);
        #1;
        check("illegal_rfunct", illegal, 1'b1);
        tick();
        check("illegal_rfunct_ex", ex_bundle(), 32'd0);
        // beq, bne, jr.
        set_id(1'b1, 6'b000100, 6'd0, 5'd1, 5'd2, 5'd0);
        tick();
        check("beq_ex", ex_bundle(), 32'b0_001_1000);
        set_id(1'b1, 6'b000101, 6'd0, 5'd1, 5'd2, 5'd0);
        tick();
        check("bne_ex", ex_bundle(), 32'b0_001_0100);
        set_id(1'b1, 6'b000000, 6'b001000, 5'd31, 5'd0, 5'd0);
        tick();
        check("jr_ex", ex_bundle(), 32'b0_010_0001);
        // add rd=0 never writes.
        set_id(1'b1, 6'b000000, 6'b100000, 5'd1, 5'd2, 5'd0);
        tick();
        nop();
        tick();
        check("jr_wb_noreg", wb_regwrite, 1'b0);
        tick();
        check("add_r0_wb", wb_regwrite, 1'b0);
        drain();

        // Reset mid-operation.
        set_id(1'b1, 6'b100011, 6'd0, 5'd0, 5'd3, 5'd0);
        tick();
        nop();
        tick();
        check("midrst_pre_mem_read", mem_read, 1'b1);
        reset = 1'b1;
        tick();
        check("midrst_outputs", all_outs(), 32'd0);
        reset = 1'b0;
        drain();

`ifdef PCU_MUL_EN
        // mul r8 with MUL_LAT=4; addi r10 waits in ID behind it.
        set_id(1'b1, 6'b011100, 6'b000010, 5'd1, 5'd2, 5'd8);
        #1;
        check("mul_legal", illegal, 1'b0);
        tick();
        set_id(1'b1, 6'b001000, 6'd0, 5'd0, 5'd10, 5'd0);
        for (int i = 1; i <= 3; i++) begin
            check("mul_busy", ex_mul_busy, 1'b1);
            check("mul_stall", stall, 1'b1);
            check("mul_held_ex", ex_aluop, 3'b111);
            tick();
        end
        check("mul_last_busy", ex_mul_busy, 1'b0);
        check("mul_last_stall", stall, 1'b0);
        check("mul_last_ex", ex_aluop, 3'b111);
        tick();
        check("mul_addi_ex", ex_bundle(), 32'b1_000_0000);
        check("mul_wb_bubble", {wb_regwrite, wb_wreg}, {1'b0, 5'd0});
        nop();
        tick();
        check("mul_wb", {wb_regwrite, wb_wreg}, {1'b1, 5'd8});
        drain();
`else
        set_id(1'b1, 6'b011100, 6'b000010, 5'd1, 5'd2, 5'd8);
        #1;
        check("mul_illegal", illegal, 1'b1);
        tick();
        check("mul_nop_ex", ex_bundle(), 32'd0);
        check("mul_busy_tied", ex_mul_busy, 1'b0);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
